// File: rtl/mcmdu.sv
// Iterative multiply/divide unit with hi/lo result registers.
// Multiplies use radix-2 Booth (signed) or shift-add (unsigned). Divides
// use restoring division on magnitudes, with the signs fixed up at the end.
// Each operation takes WIDTH iteration cycles plus one finish cycle.
// WIDTH must be even and at least 4. DIV_EN=0 removes the divide opcodes.
module mcmdu #(
    parameter int WIDTH  = 32,
    parameter int DIV_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     count;

    logic [AW-1:0]     acc;
    logic [WIDTH-1:0]  shreg;
    logic              booth_bit;
    logic [AW-1:0]     operand;
    logic [1:0]        op_q;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    logic              accept;
    logic              is_div;
    logic              is_signed;
    logic              in_signed;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;

    logic [AW-1:0]     add_x;
    logic              add_sub;
    logic [AW-1:0]     sum;
    logic              use_sum;
    logic [AW-1:0]     mult_pick;
    logic [AW-1:0]     step_acc;
    logic [WIDTH-1:0]  step_shreg;

    logic [WIDTH-1:0]  res_hi;
    logic [WIDTH-1:0]  res_lo;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign in_signed = ~op[0];
    assign accept    = (state_q == IDLE) && start && ((DIV_EN != 0) || !op[1]);
    assign a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;

    // Next-state decode and the busy flag, which covers RUN and FIN.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and iteration counter; the counter only runs in RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN) begin
                count <= count + CW'(1);
            end else begin
                count <= '0;
            end
        end
    end

    // Operand selection for the one shared adder/subtractor.
    always_comb begin
        add_x   = acc;
        add_sub = 1'b0;
        if (is_div) begin
            add_x   = {1'b0, acc[WIDTH-1:0], shreg[WIDTH-1]};
            add_sub = 1'b1;
        end else begin
            add_sub = is_signed && shreg[0] && !booth_bit;
        end
        sum = add_x + (add_sub ? ~operand : operand) + {{(AW-1){1'b0}}, add_sub};
    end

    // One iteration: Booth/shift-add step for multiply, restoring step for divide.
    always_comb begin
        step_acc   = acc;
        step_shreg = shreg;
        use_sum    = is_signed ? (shreg[0] ^ booth_bit) : shreg[0];
        mult_pick  = acc;
        if (is_div) begin
            if (!div_zero) begin
                step_acc   = sum[AW-1] ? add_x : sum;
                step_shreg = {shreg[WIDTH-2:0], ~sum[AW-1]};
            end
        end else begin
            mult_pick  = use_sum ? sum : acc;
            step_acc   = {mult_pick[AW-1], mult_pick[AW-1:1]};
            step_shreg = {mult_pick[0], shreg[WIDTH-1:1]};
        end
    end

    // Datapath registers: operands captured on acceptance, stepped during RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            shreg     <= '0;
            booth_bit <= 1'b0;
            operand   <= '0;
            op_q      <= 2'b00;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            acc       <= '0;
            booth_bit <= 1'b0;
            op_q      <= op;
            if (op[1]) begin
                shreg    <= (b == '0) ? a : a_mag;
                operand  <= {2'b00, b_mag};
                div_zero <= (b == '0);
                neg_q    <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r    <= in_signed && a[WIDTH-1];
            end else begin
                shreg    <= b;
                operand  <= in_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                div_zero <= 1'b0;
                neg_q    <= 1'b0;
                neg_r    <= 1'b0;
            end
        end else if (state_q == RUN) begin
            acc       <= step_acc;
            shreg     <= step_shreg;
            booth_bit <= shreg[0];
        end
    end

    // Final result formatting, including sign fix-up and divide-by-zero values.
    always_comb begin
        res_hi = acc[WIDTH-1:0];
        res_lo = shreg;
        if (is_div) begin
            if (div_zero) begin
                res_hi = shreg;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_lo = neg_q ? -shreg : shreg;
            end
        end
    end

    // hi/lo/div0 registers: results land in FIN, direct writes only when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            div0 <= 1'b0;
            done <= 1'b0;
        end else if (state_q == FIN) begin
            hi   <= res_hi;
            lo   <= res_lo;
            div0 <= is_div && div_zero;
            done <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state_q == IDLE) begin
                if (whi) begin
                    hi <= wdata;
                end
                if (wlo) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcmdu.sv
// Self-checking bench for mcmdu: a 32-bit divide-capable instance, an
// 8-bit instance and an 8-bit multiply-only instance sharing its inputs.
module tb_mcmdu;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } vec_t;

    logic        clock;
    logic        reset;

    logic        start32;
    logic [1:0]  op32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        whi32;
    logic        wlo32;
    logic [31:0] wdata32;
    logic        busy32;
    logic        done32;
    logic [31:0] hi32;
    logic [31:0] lo32;
    logic        div0_32;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        whi8;
    logic        wlo8;
    logic [7:0]  wdata8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;
    logic        div0_8;
    logic        busy8n;
    logic        done8n;
    logic [7:0]  hi8n;
    logic [7:0]  lo8n;
    logic        div0_8n;

    int checks;
    int failures;

    vec_t vecs[15];

    mcmdu #(.WIDTH(32), .DIV_EN(1)) u32 (
        .clock(clock), .reset(reset), .start(start32), .op(op32),
        .a(a32), .b(b32), .whi(whi32), .wlo(wlo32), .wdata(wdata32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div0(div0_32)
    );

    mcmdu #(.WIDTH(8), .DIV_EN(1)) u8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8),
        .a(a8), .b(b8), .whi(whi8), .wlo(wlo8), .wdata(wdata8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div0(div0_8)
    );

    mcmdu #(.WIDTH(8), .DIV_EN(0)) u8n (
        .clock(clock), .reset(reset), .start(start8), .op(op8),
        .a(a8), .b(b8), .whi(whi8), .wlo(wlo8), .wdata(wdata8),
        .busy(busy8n), .done(done8n), .hi(hi8n), .lo(lo8n), .div0(div0_8n)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case some sequence wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a 32-bit op, let it be accepted, then scramble the operands.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start32 = 1'b1;
        op32    = op;
        a32     = a;
        b32     = b;
        @(posedge clock);
        #1;
        start32 = 1'b0;
        op32    = ~op;
        a32     = $urandom;
        b32     = $urandom;
    endtask

    task automatic applyStimulus8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        start8 = 1'b1;
        op8    = op;
        a8     = a;
        b8     = b;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        op8    = ~op;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
    endtask

    // Count busy cycles until done is seen; -1 means it never came.
    task automatic waitDone32(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (done32) begin
                seen = 1'b1;
                break;
            end
            if (busy32) n++;
        end
        if (!seen) n = -1;
    endtask

    task automatic waitDone8(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (done8) begin
                seen = 1'b1;
                break;
            end
            if (busy8) n++;
        end
        if (!seen) n = -1;
    endtask

    initial begin
        int n;
        int nb;
        int dones;
        bit seen;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[5]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[9]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[10] = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[11] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[13] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[14] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

        reset   = 1'b1;
        start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        whi32   = 1'b0; wlo32 = 1'b0; wdata32 = '0;
        start8  = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        whi8    = 1'b0; wlo8 = 1'b0; wdata8 = '0;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset busy", {31'b0, busy32}, 32'h0);
        checkOutput("reset done", {31'b0, done32}, 32'h0);
        checkOutput("reset hi", hi32, 32'h0);
        checkOutput("reset lo", lo32, 32'h0);
        checkOutput("reset div0", {31'b0, div0_32}, 32'h0);
        checkOutput("reset hi8", {24'b0, hi8}, 32'h0);

        // Direct writes while idle.
        whi32 = 1'b1; wdata32 = 32'hAAAA0001;
        @(negedge clock);
        whi32 = 1'b0;
        checkOutput("mthi hi", hi32, 32'hAAAA0001);
        checkOutput("mthi lo", lo32, 32'h0);
        wlo32 = 1'b1; wdata32 = 32'h55550002;
        @(negedge clock);
        wlo32 = 1'b0;
        checkOutput("mtlo lo", lo32, 32'h55550002);
        checkOutput("mtlo hi", hi32, 32'hAAAA0001);
        whi32 = 1'b1; wlo32 = 1'b1; wdata32 = 32'h0BADF00D;
        @(negedge clock);
        whi32 = 1'b0; wlo32 = 1'b0;
        checkOutput("mtboth hi", hi32, 32'h0BADF00D);
        checkOutput("mtboth lo", lo32, 32'h0BADF00D);

        // Table of 32-bit operations.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone32(n);
            checkOutput($sformatf("vec%0d latency", i), n, 33);
            checkOutput($sformatf("vec%0d hi", i), hi32, vecs[i].hi);
            checkOutput($sformatf("vec%0d lo", i), lo32, vecs[i].lo);
            checkOutput($sformatf("vec%0d div0", i), {31'b0, div0_32}, {31'b0, vecs[i].div0});
            @(negedge clock);
            checkOutput($sformatf("vec%0d done pulse", i), {31'b0, done32}, 32'h0);
        end

        // Start together with mtlo in the same idle cycle.
        @(negedge clock);
        start32 = 1'b1; op32 = 2'b01; a32 = 32'h3; b32 = 32'h4;
        wlo32 = 1'b1; wdata32 = 32'hDEADBEEF;
        @(negedge clock);
        start32 = 1'b0; wlo32 = 1'b0;
        checkOutput("start+mtlo lo", lo32, 32'hDEADBEEF);
        checkOutput("start+mtlo busy", {31'b0, busy32}, 32'h1);
        waitDone32(n);
        checkOutput("start+mtlo result lo", lo32, 32'h0000000C);
        checkOutput("start+mtlo result hi", hi32, 32'h0);

        // Second start and writes during RUN must be ignored.
        applyStimulus(2'b01, 32'h10, 32'h10);
        repeat (5) @(negedge clock);
        start32 = 1'b1; op32 = 2'b11; a32 = 32'h99; b32 = 32'h3;
        whi32 = 1'b1; wlo32 = 1'b1; wdata32 = 32'h1234;
        @(negedge clock);
        start32 = 1'b0; whi32 = 1'b0; wlo32 = 1'b0;
        waitDone32(n);
        checkOutput("ignore restart latency", n, 27);
        checkOutput("ignore restart hi", hi32, 32'h0);
        checkOutput("ignore restart lo", lo32, 32'h00000100);
        @(negedge clock);
        checkOutput("ignore restart idle", {31'b0, busy32}, 32'h0);

        // Reset 10 cycles into an operation aborts it.
        applyStimulus(2'b00, 32'h5, 32'h6);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort busy", {31'b0, busy32}, 32'h0);
        checkOutput("abort done", {31'b0, done32}, 32'h0);
        checkOutput("abort hi", hi32, 32'h0);
        checkOutput("abort lo", lo32, 32'h0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done32 || busy32) dones++;
        end
        checkOutput("abort no done", dones, 0);
        checkOutput("abort lo held", lo32, 32'h0);

        // 8-bit: most-negative squared, then back-to-back start in done cycle.
        applyStimulus8(2'b00, 8'h80, 8'h80);
        waitDone8(n);
        checkOutput("w8 mult latency", n, 9);
        checkOutput("w8 mult hi", {24'b0, hi8}, 32'h40);
        checkOutput("w8 mult lo", {24'b0, lo8}, 32'h00);
        checkOutput("w8n mult hi", {24'b0, hi8n}, 32'h40);
        start8 = 1'b1; op8 = 2'b01; a8 = 8'h0F; b8 = 8'h0F;
        @(posedge clock);
        #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        waitDone8(n);
        checkOutput("w8 b2b latency", n, 9);
        checkOutput("w8 b2b hi", {24'b0, hi8}, 32'h00);
        checkOutput("w8 b2b lo", {24'b0, lo8}, 32'hE1);
        checkOutput("w8n b2b lo", {24'b0, lo8n}, 32'hE1);

        // Divide on the shared 8-bit inputs: multiply-only instance ignores it.
        applyStimulus8(2'b10, 8'h80, 8'hFF);
        nb   = 0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (busy8n || done8n) nb++;
            if (done8) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("w8 div done seen", {31'b0, seen}, 32'h1);
        checkOutput("w8n div ignored", nb, 0);
        checkOutput("w8 div hi", {24'b0, hi8}, 32'h00);
        checkOutput("w8 div lo", {24'b0, lo8}, 32'h80);
        checkOutput("w8n hi held", {24'b0, hi8n}, 32'h00);
        checkOutput("w8n lo held", {24'b0, lo8n}, 32'hE1);

        // 8-bit divide by zero and signed divide.
        applyStimulus8(2'b11, 8'h5A, 8'h00);
        waitDone8(n);
        checkOutput("w8 div0 latency", n, 9);
        checkOutput("w8 div0 hi", {24'b0, hi8}, 32'h5A);
        checkOutput("w8 div0 lo", {24'b0, lo8}, 32'hFF);
        checkOutput("w8 div0 flag", {31'b0, div0_8}, 32'h1);
        applyStimulus8(2'b10, 8'hF9, 8'h02);
        waitDone8(n);
        checkOutput("w8 sdiv hi", {24'b0, hi8}, 32'hFF);
        checkOutput("w8 sdiv lo", {24'b0, lo8}, 32'hFD);
        checkOutput("w8 sdiv div0 clr", {31'b0, div0_8}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
